// File: rtl/capi_command_arbiter_pkg.sv
// capi_command_arbiter_pkg
// Shared types for the CAPI command arbiter: PSL command/response structs,
// AFU command codes, tag type and the odd-parity helper used for every
// parity field driven toward the PSL.
package capi_command_arbiter_pkg;

  typedef byte unsigned tag_t;
  typedef logic [63:0]  pointer_t;

  typedef enum logic [12:0] {
    RESTART    = 13'h0001,
    READ_CL_NA = 13'h0A00,
    READ_CL_S  = 13'h0A50,
    WRITE_NA   = 13'h0D00,
    WRITE_MI   = 13'h0D60
  } afu_command_t;

  localparam logic [2:0] CAPI_DEFAULT_ABT = 3'b000;
  localparam logic [7:0] RSP_DONE         = 8'h00;

  // Command credit report from the PSL (ha_croom).
  typedef struct packed {
    logic [7:0] room;
  } CommandInterfaceInput;

  // Command bus toward the PSL.
  typedef struct packed {
    logic         valid;
    tag_t         tag;
    logic         tag_parity;
    afu_command_t command;
    logic         command_parity;
    logic [2:0]   abt;
    pointer_t     address;
    logic         address_parity;
    logic [15:0]  context_handle;
    logic [11:0]  size;
  } CommandInterfaceOutput;

  // Response bus from the PSL. credits is a signed return count.
  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic              tag_parity;
    logic [7:0]        response;
    logic signed [8:0] credits;
  } ResponseInterface;

  // Odd parity: the returned bit makes the total number of ones odd.
  // Zero-extending a narrower field does not change the result.
  function automatic logic odd_parity(input logic [63:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/capi_command_arbiter_if.sv
// capi_command_arbiter_if
// Requester-side bus of the command arbiter.
//   master : AFU engines (drive requests, receive grants and responses)
//   slave  : the arbiter
// Handshake: a requester raises req_valid[i] with command/address/size and
// holds all of them stable until it sees req_ready[i]=1 in the same cycle;
// that cycle is the accept and req_tag carries the assigned tag. rsp_valid[i]
// is a single-cycle, unacknowledged delivery of a completion for a tag that
// requester i owns.
interface capi_command_arbiter_if
  import capi_command_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  afu_command_t       req_command [NUM_REQ];
  pointer_t           req_address [NUM_REQ];
  logic [11:0]        req_size    [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic [7:0]         req_tag;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [7:0]         rsp_tag;
  logic [7:0]         rsp_code;

  modport master (
    output req_valid, req_command, req_address, req_size,
    input  req_ready, req_tag, rsp_valid, rsp_tag, rsp_code
  );

  modport slave (
    input  req_valid, req_command, req_address, req_size,
    output req_ready, req_tag, rsp_valid, rsp_tag, rsp_code
  );
endinterface

// File: rtl/capi_command_arbiter_tag_allocator.sv
// capi_tag_allocator
// Tag free-map with lowest-free-first allocation and a per-tag owner table.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   alloc_en       : mark alloc_tag busy and record alloc_owner
//   alloc_owner    : requester index owning the new tag
//   alloc_tag      : lowest free tag (valid when tag_available)
//   tag_available  : at least one tag free
//   free_en        : release free_tag
//   free_tag       : tag being released; also the lookup index
//   free_tag_busy  : free_tag is currently busy
//   free_tag_owner : owner recorded for free_tag
//   busy           : any tag outstanding
// A tag released in cycle N is only visible as free from cycle N+1 because
// allocation decodes the registered map.
module capi_tag_allocator #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_TAGS = 32,
  localparam int REQ_W   = $clog2(NUM_REQ),
  localparam int TAG_W   = $clog2(NUM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [REQ_W-1:0] alloc_owner,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             tag_available,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag,
  output logic             free_tag_busy,
  output logic [REQ_W-1:0] free_tag_owner,
  output logic             busy
);

  logic [NUM_TAGS-1:0] busy_map;
  logic [REQ_W-1:0]    owner_q [NUM_TAGS];

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_map[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign tag_available  = ~&busy_map;
  assign free_tag_busy  = busy_map[free_tag];
  assign free_tag_owner = owner_q[free_tag];
  assign busy           = |busy_map;

  // alloc and free never address the same tag in one cycle: alloc only picks
  // free tags, free only acts on busy ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_map <= '0;
      for (int i = 0; i < NUM_TAGS; i++) owner_q[i] <= '0;
    end else begin
      if (alloc_en) begin
        busy_map[alloc_tag] <= 1'b1;
        owner_q[alloc_tag]  <= alloc_owner;
      end
      if (free_en) busy_map[free_tag] <= 1'b0;
    end
  end

endmodule

// File: rtl/capi_command_arbiter.sv
// capi_command_arbiter
// Shares the PSL command interface among NUM_REQ AFU requesters: round-robin
// arbitration, tag allocation, command credit tracking and response routing.
// Ports:
//   clock, reset : PSL clock, asynchronous active-high reset
//   job_start    : pulse; loads credits from command_in.room, rr pointer to 0
//   command_in   : PSL credit report (room)
//   command_out  : registered command to the PSL, valid for one cycle
//   response     : PSL response bus
//   req_if       : requester bus (slave modport)
//   busy         : any tag outstanding
//   error        : sticky protocol error
// Optional feature macro: CAPI_RESPONSE_PARITY_CHECK_EN -- when defined, a
// response whose tag_parity is wrong is dropped (tag stays busy, no credits
// returned) and error is set.
module capi_command_arbiter
  import capi_command_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_TAGS = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   job_start,
  input  CommandInterfaceInput   command_in,
  output CommandInterfaceOutput  command_out,
  input  ResponseInterface       response,
  capi_command_arbiter_if.slave  req_if,
  output logic                   busy,
  output logic                   error
);

  localparam int REQ_W = $clog2(NUM_REQ);
  localparam int TAG_W = $clog2(NUM_TAGS);

  logic [7:0]          credits_q;
  logic [7:0]          room_q;
  logic [REQ_W-1:0]    rr_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [7:0]          rsp_tag_q;
  logic [7:0]          rsp_code_q;

  // ---------------- round-robin arbitration ----------------
  logic [REQ_W-1:0] winner;
  logic [REQ_W-1:0] rr_next;
  logic             found;
  int               cand;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req_if.req_valid[REQ_W'(cand)]) begin
        found  = 1'b1;
        winner = REQ_W'(cand);
      end
    end
  end

  assign rr_next = (winner == REQ_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // ---------------- tag allocator ----------------
  logic [TAG_W-1:0] alloc_tag;
  logic             tag_available;
  logic             free_tag_busy;
  logic [REQ_W-1:0] free_tag_owner;
  logic             issue;
  logic             rsp_accept;

  capi_tag_allocator #(
    .NUM_REQ  (NUM_REQ),
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_allocator (
    .clock          (clock),
    .reset          (reset),
    .alloc_en       (issue),
    .alloc_owner    (winner),
    .alloc_tag      (alloc_tag),
    .tag_available  (tag_available),
    .free_en        (rsp_accept),
    .free_tag       (response.tag[TAG_W-1:0]),
    .free_tag_busy  (free_tag_busy),
    .free_tag_owner (free_tag_owner),
    .busy           (busy)
  );

  // A job_start cycle never issues: the freshly loaded credit value wins.
  assign issue = found && (credits_q != 8'd0) && tag_available && !job_start;

  assign req_if.req_ready = issue ? (NUM_REQ'(1) << winner) : '0;
  assign req_if.req_tag   = issue ? 8'(alloc_tag) : 8'd0;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_tag   = rsp_tag_q;
  assign req_if.rsp_code  = rsp_code_q;

  // ---------------- response qualification ----------------
  logic in_range;
  logic rsp_take;     // response participates (credits counted)
  logic parity_err;
  logic tag_err;

  // 9-bit compare so NUM_TAGS = 256 stays meaningful.
  assign in_range = ({1'b0, response.tag} < 9'(NUM_TAGS));

`ifdef CAPI_RESPONSE_PARITY_CHECK_EN
  logic parity_ok;
  assign parity_ok  = (response.tag_parity == odd_parity(64'(response.tag)));
  assign rsp_take   = response.valid && parity_ok;
  assign parity_err = response.valid && !parity_ok;
`else
  logic unused_tag_parity;
  assign unused_tag_parity = response.tag_parity;
  assign rsp_take          = response.valid;
  assign parity_err        = 1'b0;
`endif

  assign rsp_accept = rsp_take && in_range && free_tag_busy;
  assign tag_err    = rsp_take && !(in_range && free_tag_busy);

  // ---------------- credit arithmetic ----------------
  logic signed [10:0] credit_sum;
  logic [7:0]         credits_d;
  logic               credit_err;

  always_comb begin
    credit_sum = $signed({3'b000, credits_q});
    if (issue)    credit_sum = credit_sum - 11'sd1;
    if (rsp_take) credit_sum = credit_sum + $signed({{2{response.credits[8]}}, response.credits});
    credit_err = 1'b0;
    if (credit_sum < 11'sd0) begin
      credits_d  = 8'd0;
      credit_err = 1'b1;
    end else if (credit_sum > $signed({3'b000, room_q})) begin
      credits_d  = room_q;
      credit_err = 1'b1;
    end else begin
      credits_d  = credit_sum[7:0];
    end
  end

  // ---------------- registered state and outputs ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credits_q   <= '0;
      room_q      <= '0;
      rr_q        <= '0;
      command_out <= '0;
      rsp_valid_q <= '0;
      rsp_tag_q   <= '0;
      rsp_code_q  <= '0;
      error       <= 1'b0;
    end else begin
      if (job_start) begin
        credits_q <= command_in.room;
        room_q    <= command_in.room;
        rr_q      <= '0;
      end else begin
        credits_q <= credits_d;
        if (issue) rr_q <= rr_next;
      end

      error <= error | tag_err | parity_err | (credit_err & ~job_start);

      if (issue) begin
        command_out.valid          <= 1'b1;
        command_out.tag            <= 8'(alloc_tag);
        command_out.tag_parity     <= odd_parity(64'(alloc_tag));
        command_out.command        <= req_if.req_command[winner];
        command_out.command_parity <= odd_parity(64'(req_if.req_command[winner]));
        command_out.abt            <= CAPI_DEFAULT_ABT;
        command_out.address        <= req_if.req_address[winner];
        command_out.address_parity <= odd_parity(req_if.req_address[winner]);
        command_out.context_handle <= 16'd0;
        command_out.size           <= req_if.req_size[winner];
      end else begin
        command_out <= '0;
      end

      if (rsp_accept) begin
        rsp_valid_q <= NUM_REQ'(1) << free_tag_owner;
        rsp_tag_q   <= response.tag;
        rsp_code_q  <= response.response;
      end else begin
        rsp_valid_q <= '0;
        rsp_tag_q   <= '0;
        rsp_code_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_capi_command_arbiter.sv
// tb_capi_command_arbiter
// Directed bench for capi_command_arbiter (NUM_REQ=4, NUM_TAGS=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// falling edge.
module tb_capi_command_arbiter;
  import capi_command_arbiter_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int NUM_TAGS = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic job_start;
  CommandInterfaceInput  command_in;
  CommandInterfaceOutput command_out;
  ResponseInterface      response;
  logic busy;
  logic error;

  always #5 clock = ~clock;

  capi_command_arbiter_if #(.NUM_REQ(NUM_REQ)) req_bus ();

  capi_command_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .NUM_TAGS (NUM_TAGS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .job_start   (job_start),
    .command_in  (command_in),
    .command_out (command_out),
    .response    (response),
    .req_if      (req_bus),
    .busy        (busy),
    .error       (error)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_tag;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    job_start         = 1'b0;
    response          = '0;
    req_bus.req_valid = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_rsp(input logic [7:0] tag, input logic [8:0] credits, input logic good_parity);
    response            = '0;
    response.valid      = 1'b1;
    response.tag        = tag;
    response.tag_parity = good_parity ? ~(^tag) : (^tag);
    response.response   = RSP_DONE;
    response.credits    = credits;
  endtask

  task automatic start_job(input logic [7:0] room);
    command_in.room = room;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    command_in = '0;
    clear_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bus.req_command[i] = READ_CL_NA;
      req_bus.req_address[i] = 64'h2000 + 64'(i) * 64'h100;
      req_bus.req_size[i]    = 12'd128;
    end
    #1 reset = 1'b1;
    #1;
    check("reset_cmd_out",   64'(command_out), 64'd0);
    check("reset_req_ready", 64'(req_bus.req_ready), 64'd0);
    check("reset_req_tag",   64'(req_bus.req_tag), 64'd0);
    check("reset_rsp_valid", 64'(req_bus.rsp_valid), 64'd0);
    check("reset_busy",      64'(busy), 64'd0);
    check("reset_error",     64'(error), 64'd0);
    tick();
    reset = 1'b0;

    // ---- single request ----
    req_bus.req_valid      = 4'b0001;
    req_bus.req_address[0] = 64'h1000;
    command_in.room        = 8'd8;
    job_start              = 1'b1;
    settle();
    check("single_deferred_by_job_start", 64'(req_bus.req_ready), 64'd0);
    tick();
    job_start = 1'b0;
    settle();
    check("single_ready", 64'(req_bus.req_ready), 64'b0001);
    check("single_tag",   64'(req_bus.req_tag), 64'd0);
    tick();
    req_bus.req_valid = '0;
    settle();
    check("single_cmd_valid",   64'(command_out.valid), 64'd1);
    check("single_cmd_tag",     64'(command_out.tag), 64'd0);
    check("single_cmd_code",    64'(command_out.command), 64'h0A00);
    check("single_cmd_addr",    command_out.address, 64'h1000);
    check("single_cmd_size",    64'(command_out.size), 64'd128);
    check("single_tag_par",     64'(command_out.tag_parity), 64'd1);
    check("single_cmd_par",     64'(command_out.command_parity), 64'd1);
    check("single_addr_par",    64'(command_out.address_parity), 64'd0);
    check("single_abt_ctx",     64'({command_out.abt, command_out.context_handle}), 64'd0);
    check("single_busy",        64'(busy), 64'd1);
    check("single_credits_7",   64'(dut.credits_q), 64'd7);
    tick();
    send_rsp(8'd0, 9'd1, 1'b1);
    settle();
    check("single_cmd_pulse",   64'(command_out.valid), 64'd0);
    check("single_rsp_not_yet", 64'(req_bus.rsp_valid), 64'd0);
    tick();
    response = '0;
    settle();
    check("single_rsp_valid",   64'(req_bus.rsp_valid), 64'b0001);
    check("single_rsp_tag",     64'(req_bus.rsp_tag), 64'd0);
    check("single_rsp_code",    64'(req_bus.rsp_code), 64'(RSP_DONE));
    check("single_busy_clear",  64'(busy), 64'd0);
    check("single_credits_8",   64'(dut.credits_q), 64'd8);
    tick();
    settle();
    check("single_rsp_pulse",   64'(req_bus.rsp_valid), 64'd0);
    req_bus.req_address[0] = 64'h2000;

    // ---- round robin ----
    tick();
    start_job(8'd8);
    req_bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rr_ready", 64'(req_bus.req_ready), 64'(4'b0001 << (k % 4)));
      check("rr_tag",   64'(req_bus.req_tag), 64'(k));
      if (k > 0) begin
        exp_tag = exp_q.pop_front();
        check("rr_cmd_tag",  64'(command_out.tag), 64'(exp_tag));
        check("rr_cmd_addr", command_out.address, 64'h2000 + 64'((k - 1) % 4) * 64'h100);
      end
      exp_q.push_back(8'(k));
      tick();
    end
    req_bus.req_valid = '0;
    settle();
    exp_tag = exp_q.pop_front();
    check("rr_last_cmd_tag", 64'(command_out.tag), 64'(exp_tag));
    check("rr_queue_empty",  64'(exp_q.size()), 64'd0);

    // ---- credit exhaustion ----
    tick();
    apply_reset();
    start_job(8'd2);
    req_bus.req_valid = 4'b0111;
    settle();
    check("cred_grant0", 64'(req_bus.req_ready), 64'b0001);
    tick();
    req_bus.req_valid = 4'b0110;
    settle();
    check("cred_grant1", 64'(req_bus.req_ready), 64'b0010);
    check("cred_tag1",   64'(req_bus.req_tag), 64'd1);
    tick();
    req_bus.req_valid = 4'b0100;
    settle();
    check("cred_wait_a", 64'(req_bus.req_ready), 64'd0);
    tick();
    send_rsp(8'd0, 9'd1, 1'b1);
    settle();
    check("cred_wait_rsp_cycle", 64'(req_bus.req_ready), 64'd0);
    tick();
    response = '0;
    settle();
    check("cred_grant2",     64'(req_bus.req_ready), 64'b0100);
    check("cred_tag_reused", 64'(req_bus.req_tag), 64'd0);
    check("cred_rsp_owner",  64'(req_bus.rsp_valid), 64'b0001);
    tick();
    req_bus.req_valid = '0;
    settle();
    check("cred_cmd_valid", 64'(command_out.valid), 64'd1);
    check("cred_no_error",  64'(error), 64'd0);

    // ---- tag exhaustion ----
    tick();
    apply_reset();
    start_job(8'd64);
    req_bus.req_valid = 4'b0001;
    for (int i = 0; i < NUM_TAGS; i++) begin
      settle();
      check("tags_ready", 64'(req_bus.req_ready), 64'b0001);
      check("tags_tag",   64'(req_bus.req_tag), 64'(i));
      tick();
    end
    settle();
    check("tags_full_stall", 64'(req_bus.req_ready), 64'd0);
    check("tags_full_busy",  64'(busy), 64'd1);
    tick();
    send_rsp(8'd7, 9'd1, 1'b1);
    settle();
    check("tags_free_gap", 64'(req_bus.req_ready), 64'd0);
    tick();
    response = '0;
    settle();
    check("tags_reuse_ready", 64'(req_bus.req_ready), 64'b0001);
    check("tags_reuse_tag",   64'(req_bus.req_tag), 64'd7);
    check("tags_rsp_tag",     64'(req_bus.rsp_tag), 64'd7);
    tick();
    req_bus.req_valid = '0;
    settle();
    check("tags_cmd_tag", 64'(command_out.tag), 64'd7);
    check("tags_credits", 64'(dut.credits_q), 64'd32);
    check("tags_no_error", 64'(error), 64'd0);

    // ---- bad responses ----
    tick();
    apply_reset();
    send_rsp(8'd5, 9'd0, 1'b1);
    tick();
    response = '0;
    settle();
    check("bad_free_no_rsp", 64'(req_bus.rsp_valid), 64'd0);
    check("bad_free_error",  64'(error), 64'd1);
    tick();
    apply_reset();
    settle();
    check("bad_error_cleared", 64'(error), 64'd0);
    tick();
    send_rsp(8'd200, 9'd0, 1'b1);
    tick();
    response = '0;
    settle();
    check("bad_range_no_rsp", 64'(req_bus.rsp_valid), 64'd0);
    check("bad_range_error",  64'(error), 64'd1);

    // ---- credit overflow saturates at room ----
    tick();
    apply_reset();
    start_job(8'd4);
    req_bus.req_valid = 4'b0001;
    tick();
    req_bus.req_valid = '0;
    send_rsp(8'd0, 9'd5, 1'b1);
    tick();
    response = '0;
    settle();
    check("ovf_rsp_valid", 64'(req_bus.rsp_valid), 64'b0001);
    check("ovf_error",     64'(error), 64'd1);
    check("ovf_saturate",  64'(dut.credits_q), 64'd4);

    // ---- credit underflow saturates at zero ----
    tick();
    apply_reset();
    start_job(8'd1);
    req_bus.req_valid = 4'b0001;
    tick();
    req_bus.req_valid = '0;
    send_rsp(8'd0, 9'h1FF, 1'b1);
    tick();
    response = '0;
    settle();
    check("unf_error",    64'(error), 64'd1);
    check("unf_saturate", 64'(dut.credits_q), 64'd0);

    // ---- response tag parity ----
    tick();
    apply_reset();
    start_job(8'd8);
    req_bus.req_valid = 4'b0001;
    tick();
    req_bus.req_valid = '0;
    send_rsp(8'd0, 9'd1, 1'b0);
    tick();
    response = '0;
    settle();
`ifdef CAPI_RESPONSE_PARITY_CHECK_EN
    check("par_dropped",    64'(req_bus.rsp_valid), 64'd0);
    check("par_error",      64'(error), 64'd1);
    check("par_tag_busy",   64'(busy), 64'd1);
    check("par_no_credits", 64'(dut.credits_q), 64'd7);
`else
    check("par_ignored_rsp",   64'(req_bus.rsp_valid), 64'b0001);
    check("par_ignored_error", 64'(error), 64'd0);
    check("par_ignored_busy",  64'(busy), 64'd0);
    check("par_credits",       64'(dut.credits_q), 64'd8);
`endif

    // ---- asynchronous reset with 3 tags outstanding ----
    tick();
    apply_reset();
    start_job(8'd8);
    req_bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("areset_issue_tag", 64'(req_bus.req_tag), 64'(i));
      tick();
    end
    check("areset_pre_cmd_valid", 64'(command_out.valid), 64'd1);
    check("areset_pre_busy",      64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("areset_cmd_out",   64'(command_out), 64'd0);
    check("areset_busy",      64'(busy), 64'd0);
    check("areset_req_ready", 64'(req_bus.req_ready), 64'd0);
    check("areset_rsp_valid", 64'(req_bus.rsp_valid), 64'd0);
    tick();
    reset = 1'b0;
    req_bus.req_valid = '0;
    settle();
    check("areset_release_busy",  64'(busy), 64'd0);
    check("areset_release_error", 64'(error), 64'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
